add_bcd_sequencer: RTL and testbench
====================================

ADD_BCD_SEQUENCER -- requirements
Module: add_bcd_sequencer

Interface
REQ-001 SHALL have port: CLOCK_50  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  conversion request, level input, rising-edge qualified internally.
REQ-004 SHALL have port: op_a  in  8  unsigned operand A.
REQ-005 SHALL have port: op_b  in  8  unsigned operand B.
REQ-006 SHALL have port: busy  out  1  high while a conversion is in progress.
REQ-007 SHALL have port: done  out  1  one-cycle pulse when a new result is published.
REQ-008 SHALL have port: sum  out  9  published binary sum op_a+op_b.
REQ-009 SHALL have port: bcd_hund, bcd_tens, bcd_ones  out  4 each  published decimal digits of sum.
REQ-010 SHALL have port: HEX2, HEX1, HEX0  out  7 each  active-low segment patterns for bcd_hund, bcd_tens, bcd_ones.

Function
REQ-011 SHALL register start into start_q each cycle; start_edge = start & ~start_q.
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 In IDLE on start_edge SHALL capture op_a, op_b, compute 9-bit sum_work = op_a + op_b (carry kept as bit 8), clear 12-bit BCD scratch, load shift count 9, go to SHIFT.
REQ-014 In IDLE without start_edge SHALL stay in IDLE; start_edge outside IDLE SHALL be ignored, not queued.
REQ-015 Each SHIFT cycle SHALL first add 3 to every scratch nibble >= 5, then shift {scratch, sum_work} left by 1, and decrement count.
REQ-016 SHALL go SHIFT -> DONE after exactly 9 SHIFT cycles (count reaches 0).
REQ-017 In DONE SHALL publish sum and the three scratch nibbles to output registers, pulse done for that cycle, and return to IDLE next cycle.
REQ-018 Latency: capture at edge E0; SHIFT during cycles E1..E9; done high during E10..E11 interval (exactly one cycle); outputs updated at E10.
REQ-019 busy SHALL be high from the cycle after capture through the done cycle inclusive (10 cycles), low otherwise.
REQ-020 Published outputs SHALL hold their previous value for the entire conversion; no partial value ever visible.
REQ-021 Output range: sum 0..510; bcd_hund 0..5; tens/ones 0..9; no overflow flag.
REQ-022 Segment encoding (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; nibbles 10..15 SHALL drive 1111111 (blank).
REQ-023 start held high continuously SHALL trigger exactly one conversion; a new conversion needs start low for >=1 cycle then high again while IDLE.
REQ-024 start_edge in the same cycle DONE returns to IDLE SHALL be ignored (FSM is in DONE when sampled).

Reset
REQ-025 reset high at a rising edge SHALL force: state IDLE, start_q 0, busy 0, done 0, sum 0, all BCD digits 0, HEX2..HEX0 = 1000000.
REQ-026 reset SHALL override start in the same cycle; reset mid-conversion SHALL abort with no done pulse and no output update.
REQ-027 First cycle after reset deasserts with start already high SHALL NOT trigger (start_q cleared makes it an edge: it SHALL trigger) -- decided: start high on first post-reset cycle counts as a rising edge.

Verification
REQ-028 op_a=255, op_b=255, start pulse -> busy 10 cycles, done once at E10, sum=510, digits 5/1/0, HEX2=0010010, HEX1=1111001, HEX0=1000000.
REQ-029 op_a=0, op_b=0, start pulse -> sum=0, digits 0/0/0, done at E10.
REQ-030 op_a=200, op_b=57 then change operands to 1/1 at E3 -> result still 257, digits 2/5/7.
REQ-031 start held high 30 cycles with 12/34 -> exactly one done pulse, result 46; second low-high pulse -> second done.
REQ-032 start pulse at E5 during busy -> ignored, exactly one done at E10.
REQ-033 After result 510, start 99+1 and assert reset at E5 -> busy 0 and digits 0/0/0 next cycle, no done pulse; subsequent 99+1 -> 100, digits 1/0/0.

Source files
------------

// File: rtl/add_bcd_sequencer.sv
// Adds two 8-bit operands and converts the 9-bit sum to three BCD digits with
// a 9-step shift-add-3 sequence, publishing the digits and 7-segment patterns.
module add_bcd_sequencer (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [8:0] sum,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic        start_q;
    logic [8:0]  sumCapt_q;
    logic [8:0]  sumWork_q;
    logic [11:0] scratch_q;
    logic [3:0]  count_q;

    logic        startEdge;
    logic [8:0]  sumNew;
    logic [11:0] scratchAdj_d;

    assign startEdge = start & ~start_q;
    assign sumNew    = {1'b0, op_a} + {1'b0, op_b};

    function automatic logic [3:0] adjustNibble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] segOf(input logic [3:0] d);
        case (d)
            4'd0:    segOf = 7'b1000000;
            4'd1:    segOf = 7'b1111001;
            4'd2:    segOf = 7'b0100100;
            4'd3:    segOf = 7'b0110000;
            4'd4:    segOf = 7'b0011001;
            4'd5:    segOf = 7'b0010010;
            4'd6:    segOf = 7'b0000010;
            4'd7:    segOf = 7'b1111000;
            4'd8:    segOf = 7'b0000000;
            4'd9:    segOf = 7'b0010000;
            default: segOf = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        scratchAdj_d = {adjustNibble(scratch_q[11:8]),
                        adjustNibble(scratch_q[7:4]),
                        adjustNibble(scratch_q[3:0])};
    end

    // Published outputs only change in DONE, so a conversion never exposes partial digits.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            sumCapt_q <= '0;
            sumWork_q <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            bcd_hund  <= '0;
            bcd_tens  <= '0;
            bcd_ones  <= '0;
            HEX2      <= 7'b1000000;
            HEX1      <= 7'b1000000;
            HEX0      <= 7'b1000000;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            busy    <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (startEdge) begin
                        sumCapt_q <= sumNew;
                        sumWork_q <= sumNew;
                        scratch_q <= '0;
                        count_q   <= 4'd9;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_q, sumWork_q} <= {scratchAdj_d, sumWork_q} << 1;
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    sum      <= sumCapt_q;
                    bcd_hund <= scratch_q[11:8];
                    bcd_tens <= scratch_q[7:4];
                    bcd_ones <= scratch_q[3:0];
                    HEX2     <= segOf(scratch_q[11:8]);
                    HEX1     <= segOf(scratch_q[7:4]);
                    HEX0     <= segOf(scratch_q[3:0]);
                    done     <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_bcd_sequencer.sv
// Scoreboard bench for add_bcd_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_add_bcd_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [8:0] sum;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;

    add_bcd_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .bcd_hund (bcd_hund),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .HEX2     (HEX2),
        .HEX1     (HEX1),
        .HEX0     (HEX0)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int c0;
        int s;
    } exp_t;

    exp_t expQ[$];
    int   cycleCount = 0;
    int   checks     = 0;
    int   passes     = 0;
    int   busyRun    = 0;
    bit   doneInRun  = 1'b0;
    bit   busyPrev   = 1'b0;

    always @(posedge CLOCK_50) cycleCount++;

    function automatic int segRef(input int d);
        case (d)
            0:       segRef = 7'b1000000;
            1:       segRef = 7'b1111001;
            2:       segRef = 7'b0100100;
            3:       segRef = 7'b0110000;
            4:       segRef = 7'b0011001;
            5:       segRef = 7'b0010010;
            6:       segRef = 7'b0000010;
            7:       segRef = 7'b1111000;
            8:       segRef = 7'b0000000;
            9:       segRef = 7'b0010000;
            default: segRef = 7'b1111111;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Monitor: results are matched in issue order; done is expected 10 cycles after capture.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (done) begin
            doneInRun = 1'b1;
            checkOutput("busy_at_done", int'(busy), 1);
            checkOutput("done_expected", int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("done_cycle", cycleCount, e.c0 + 10);
                checkOutput("sum", int'(sum), e.s);
                checkOutput("bcd_hund", int'(bcd_hund), e.s / 100);
                checkOutput("bcd_tens", int'(bcd_tens), (e.s / 10) % 10);
                checkOutput("bcd_ones", int'(bcd_ones), e.s % 10);
                checkOutput("HEX2", int'(HEX2), segRef(e.s / 100));
                checkOutput("HEX1", int'(HEX1), segRef((e.s / 10) % 10));
                checkOutput("HEX0", int'(HEX0), segRef(e.s % 10));
            end
        end
        if (busy) begin
            busyRun++;
        end else if (busyPrev) begin
            if (doneInRun) checkOutput("busy_length", busyRun, 10);
            busyRun   = 0;
            doneInRun = 1'b0;
        end
        busyPrev = busy;
    end

    // Called just after a negedge; start is sampled at the next rising edge (E0).
    task automatic applyStimulus(input int a, input int b, input int hold, input int gap);
        op_a  = 8'(a);
        op_b  = 8'(b);
        start = 1'b1;
        expQ.push_back('{cycleCount + 1, a + b});
        repeat (hold) @(negedge CLOCK_50);
        start = 1'b0;
        repeat (gap) @(negedge CLOCK_50);
    endtask

    task automatic checkResetState();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_sum", int'(sum), 0);
        checkOutput("rst_hund", int'(bcd_hund), 0);
        checkOutput("rst_tens", int'(bcd_tens), 0);
        checkOutput("rst_ones", int'(bcd_ones), 0);
        checkOutput("rst_HEX2", int'(HEX2), 7'b1000000);
        checkOutput("rst_HEX1", int'(HEX1), 7'b1000000);
        checkOutput("rst_HEX0", int'(HEX0), 7'b1000000);
    endtask

    initial begin
        int a;
        int b;
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge CLOCK_50);
        checkResetState();
        reset = 1'b0;
        @(negedge CLOCK_50);

        applyStimulus(255, 255, 1, 12);
        applyStimulus(0, 0, 1, 12);

        applyStimulus(200, 57, 1, 0);
        repeat (2) @(negedge CLOCK_50);
        op_a = 8'd1;
        op_b = 8'd1;
        repeat (10) @(negedge CLOCK_50);

        applyStimulus(12, 34, 30, 1);
        applyStimulus(12, 34, 1, 12);

        // Edges at E5 (mid-shift) and E10 (DONE) must both be dropped.
        applyStimulus(77, 88, 1, 0);
        repeat (4) @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (12) @(negedge CLOCK_50);

        applyStimulus(255, 255, 1, 12);
        applyStimulus(99, 1, 1, 0);
        repeat (4) @(negedge CLOCK_50);
        reset = 1'b1;
        expQ.delete();
        @(negedge CLOCK_50);
        checkResetState();
        reset = 1'b0;
        repeat (12) @(negedge CLOCK_50);
        applyStimulus(99, 1, 1, 12);

        // start already high when reset releases counts as a rising edge.
        reset = 1'b1;
        start = 1'b1;
        op_a  = 8'd150;
        op_b  = 8'd150;
        @(negedge CLOCK_50);
        checkResetState();
        reset = 1'b0;
        expQ.push_back('{cycleCount + 1, 300});
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (12) @(negedge CLOCK_50);

        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            applyStimulus(a, b, 1, 10 + int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 50 && expQ.size() > 0; i++) @(negedge CLOCK_50);
        checkOutput("queue_drained", expQ.size(), 0);
        repeat (3) @(negedge CLOCK_50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
